// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-width op codes and arbiter states.
package dmem_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b000;
  localparam logic [2:0] OP_SH  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; flags when it sits at its ceiling.
module sat_counter #(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  always_comb begin
    w_at_max = (r_count == W'(MAX));
    o_sat    = w_at_max;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU (always wins, zero latency) and a device
// requester that is slotted into CPU-idle cycles with a one-cycle response pulse.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [2:0]    cpu_op,
  input  logic          cpu_we,
  input  logic          cpu_rd,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dev_req_valid,
  output logic          dev_req_ready,
  input  logic          dev_we,
  input  logic [AW-1:0] dev_addr,
  input  logic [DW-1:0] dev_wdata,
  input  logic [2:0]    dev_op,
  output logic          dev_resp_valid,
  output logic [DW-1:0] dev_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_op,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          starve
);

  arb_state_e    r_state;
  arb_state_e    w_state_next;
  logic [DW-1:0] r_dev_rdata;
  logic          w_cpu_busy;
  logic          w_idle;
  logic          w_grant;
  logic          w_wait_inc;
  logic          w_wait_clr;

  always_comb begin
    w_cpu_busy = cpu_we | cpu_rd;
    w_idle     = (r_state == ARB_IDLE);
    w_grant    = w_idle & dev_req_valid & ~w_cpu_busy & ~reset;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    dev_req_ready  = 1'b0;
    dev_resp_valid = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        dev_req_ready = w_grant;
        if (w_grant) w_state_next = ARB_RESP;
      end
      ARB_RESP: begin
        dev_resp_valid = 1'b1;
        w_state_next   = ARB_IDLE;
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  // Port mux: CPU signals are the default so its address/data are visible even when idle.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_op    = cpu_op;
    mem_we    = cpu_we & ~reset;
    mem_rd    = cpu_rd & ~reset;
    if (w_grant) begin
      mem_addr  = dev_addr;
      mem_wdata = dev_wdata;
      mem_op    = dev_op;
      mem_we    = dev_we;
      mem_rd    = ~dev_we;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign dev_rdata = r_dev_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dev_rdata <= '0;
    end else if (w_grant && !dev_we) begin
      r_dev_rdata <= mem_rdata;
    end
  end

  // The response cycle leaves the wait count untouched.
  always_comb begin
    w_wait_inc = w_idle & dev_req_valid & ~w_grant;
    w_wait_clr = w_idle & (w_grant | ~dev_req_valid);
  end

  sat_counter #(
    .MAX(STARVE_LIMIT)
  ) u_wait_cnt (
    .i_clk(clock),
    .i_rst(reset),
    .i_inc(w_wait_inc),
    .i_clr(w_wait_clr),
    .o_sat(starve)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and per-cycle reference model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_op;
  logic        cpu_we, cpu_rd;
  logic        dev_req_valid, dev_req_ready, dev_we, dev_resp_valid;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;
  logic [2:0]  dev_op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_op;
  logic        mem_we, mem_rd, starve;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .AW(32),
    .DW(32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_op(cpu_op),
    .cpu_we(cpu_we),
    .cpu_rd(cpu_rd),
    .cpu_rdata(cpu_rdata),
    .dev_req_valid(dev_req_valid),
    .dev_req_ready(dev_req_ready),
    .dev_we(dev_we),
    .dev_addr(dev_addr),
    .dev_wdata(dev_wdata),
    .dev_op(dev_op),
    .dev_resp_valid(dev_resp_valid),
    .dev_rdata(dev_rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_op(mem_op),
    .mem_we(mem_we),
    .mem_rd(mem_rd),
    .mem_rdata(mem_rdata),
    .starve(starve)
  );

  // Word memory with a preload port used only while the DUT is held in reset.
  logic [31:0] mem [0:1023];
  logic        ld_we;
  logic [31:0] ld_addr, ld_data;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    else if (ld_we) mem[ld_addr[11:2]] <= ld_data;
  end

  // Reference model: pending-response flag, refused-cycle count, last device load word.
  logic        m_resp;
  int          m_wait;
  logic [31:0] m_rdata;
  logic        e_ready, e_we, e_rd;
  logic [31:0] e_addr, e_wdata;
  logic [2:0]  e_op;

  always_comb begin
    e_ready = !m_resp && dev_req_valid && !(cpu_we || cpu_rd) && !reset;
    e_addr  = e_ready ? dev_addr  : cpu_addr;
    e_wdata = e_ready ? dev_wdata : cpu_wdata;
    e_op    = e_ready ? dev_op    : cpu_op;
    e_we    = e_ready ? dev_we    : (cpu_we && !reset);
    e_rd    = e_ready ? !dev_we   : (cpu_rd && !reset);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_resp  <= 1'b0;
      m_wait  <= 0;
      m_rdata <= '0;
    end else begin
      m_resp <= e_ready;
      if (e_ready && !dev_we) m_rdata <= mem[dev_addr[11:2]];
      if (!m_resp) begin
        if (dev_req_valid && !e_ready) m_wait <= (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
        else m_wait <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("m.ready", dev_req_ready, e_ready);
    chk("m.resp", dev_resp_valid, m_resp);
    chk("m.rdata", dev_rdata, m_rdata);
    chk("m.starve", starve, (m_wait == LIMIT));
    chk("m.addr", mem_addr, e_addr);
    chk("m.wdata", mem_wdata, e_wdata);
    chk("m.op", mem_op, e_op);
    chk("m.we", mem_we, e_we);
    chk("m.rd", mem_rd, e_rd);
    chk("m.cpu_rdata", cpu_rdata, mem[e_addr[11:2]]);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    reset = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_op = 3'b010; cpu_we = 0; cpu_rd = 0;
    dev_req_valid = 0; dev_we = 0; dev_addr = '0; dev_wdata = '0; dev_op = 3'b010;
    ld_we = 0; ld_addr = '0; ld_data = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst.ready", dev_req_ready, 1'b0);
    chk("rst.resp", dev_resp_valid, 1'b0);
    chk("rst.starve", starve, 1'b0);
    chk("rst.rdata", dev_rdata, 32'h0);

    cyc(); ld_we = 1; ld_addr = 32'h100; ld_data = 32'hDEADBEEF;
    cyc(); ld_addr = 32'h200; ld_data = 32'h12345678;
    cyc(); ld_addr = 32'h208; ld_data = 32'h0BADF00D;
    cyc(); ld_we = 0; reset = 1'b0;

    // CPU load passes straight through
    cyc(); cpu_rd = 1; cpu_addr = 32'h100;
    #3;
    chk("t1.addr", mem_addr, 32'h100);
    chk("t1.cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1.ready", dev_req_ready, 1'b0);

    // Single device load
    cyc(); cpu_rd = 0; dev_req_valid = 1; dev_we = 0; dev_addr = 32'h200;
    #3 chk("t2.ready", dev_req_ready, 1'b1);
    chk("t2.resp_n", dev_resp_valid, 1'b0);
    cyc(); dev_req_valid = 0;
    #3 chk("t2.resp", dev_resp_valid, 1'b1);
    chk("t2.rdata", dev_rdata, 32'h12345678);
    cyc();
    #3 chk("t2.resp_off", dev_resp_valid, 1'b0);
    chk("t2.hold", dev_rdata, 32'h12345678);

    // Device store blocked by three CPU stores
    cyc(); cpu_we = 1; cpu_addr = 32'h304; cpu_wdata = 32'h11112222;
    dev_req_valid = 1; dev_we = 1; dev_addr = 32'h300; dev_wdata = 32'hCAFE0001;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      #3 chk("t3.refused", dev_req_ready, 1'b0);
      chk("t3.cpu_addr", mem_addr, 32'h304);
    end
    cyc(); cpu_we = 0;
    #3 chk("t3.accept", dev_req_ready, 1'b1);
    chk("t3.addr", mem_addr, 32'h300);
    chk("t3.we", mem_we, 1'b1);
    cyc(); dev_req_valid = 0;
    #3 chk("t3.resp", dev_resp_valid, 1'b1);
    chk("t3.rdata_kept", dev_rdata, 32'h12345678);
    chk("t3.mem300", mem[32'h300 >> 2], 32'hCAFE0001);
    chk("t3.mem304", mem[32'h304 >> 2], 32'h11112222);
    cyc();
    #3 chk("t3.single", dev_resp_valid, 1'b0);

    // Starvation with the CPU busy for six cycles
    cyc(); cpu_rd = 1; cpu_addr = 32'h100;
    dev_req_valid = 1; dev_we = 0; dev_addr = 32'h208;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) cyc();
      #3 chk("t4.refused", dev_req_ready, 1'b0);
      chk("t4.starve", starve, (k >= 5));
    end
    cyc(); cpu_rd = 0;
    #3 chk("t4.accept", dev_req_ready, 1'b1);
    chk("t4.starve_acc", starve, 1'b1);
    cyc(); dev_req_valid = 0;
    #3 chk("t4.resp", dev_resp_valid, 1'b1);
    chk("t4.starve_clr", starve, 1'b0);
    chk("t4.rdata", dev_rdata, 32'h0BADF00D);

    // Back-to-back device loads
    b2b_addr[0] = 32'h200; b2b_addr[1] = 32'h208; b2b_addr[2] = 32'h100;
    b2b_data[0] = 32'h12345678; b2b_data[1] = 32'h0BADF00D; b2b_data[2] = 32'hDEADBEEF;
    cyc(); dev_req_valid = 1; dev_addr = b2b_addr[0];
    for (int i = 0; i < 3; i++) begin
      #3 chk("t5.accept", dev_req_ready, 1'b1);
      chk("t5.noresp", dev_resp_valid, 1'b0);
      cyc();
      if (i < 2) dev_addr = b2b_addr[i+1];
      else dev_req_valid = 0;
      #3 chk("t5.no_accept", dev_req_ready, 1'b0);
      chk("t5.resp", dev_resp_valid, 1'b1);
      chk("t5.rdata", dev_rdata, b2b_data[i]);
      cyc();
    end

    // Reset during the response cycle
    dev_req_valid = 1; dev_addr = 32'h200;
    #3 chk("t6.accept", dev_req_ready, 1'b1);
    cyc(); dev_req_valid = 0; reset = 1'b1;
    #3 chk("t6.resp", dev_resp_valid, 1'b0);
    chk("t6.rdata", dev_rdata, 32'h0);
    chk("t6.starve", starve, 1'b0);
    chk("t6.mem_rd", mem_rd, 1'b0);
    cyc(); reset = 1'b0; dev_req_valid = 1; dev_addr = 32'h208;
    #3 chk("t6.reaccept", dev_req_ready, 1'b1);
    cyc(); dev_req_valid = 0;
    #3 chk("t6.resp2", dev_resp_valid, 1'b1);
    chk("t6.rdata2", dev_rdata, 32'h0BADF00D);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
